// File: rtl/instruction_store.sv
// Instruction RAM: zeroes itself after reset, then serves 1-cycle fetches or accepts a streamed load.
// Fetches are only accepted in IDLE; busy (CLEAR or LOAD) drops requests with no queueing.
module instruction_store #(
  parameter int WORD  = 8,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic [WORD-1:0] fetch_addr,
  output logic [WORD-1:0] fetch_data,
  output logic            fetch_valid,
  output logic            busy,
  input  logic            load_start,
  input  logic [WORD-1:0] load_base,
  input  logic            load_valid,
  input  logic [WORD-1:0] load_data,
  input  logic            load_last,
  output logic            load_done
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD:0] DEPTH_W  = (WORD+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

  state_t          state;
  logic [AW-1:0]   clr_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [WORD-1:0] mem [DEPTH];

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [WORD-1:0] mem_wd;
  logic            fetch_ok;
  logic            fetch_in_range;
  logic [AW-1:0]   base_ptr;
  logic [AW-1:0]   wr_ptr_next;

  always_comb begin
    fetch_ok       = (state == IDLE) && fetch_req;
    // Widened compare so DEPTH == 2**WORD never overflows and high addresses never alias.
    fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
    base_ptr       = AW'({1'b0, load_base} % DEPTH_W);
    wr_ptr_next    = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    mem_we         = !rst && ((state == CLEAR) || ((state == LOAD) && load_valid));
    mem_wa         = (state == CLEAR) ? clr_ptr : wr_ptr;
    mem_wd         = (state == CLEAR) ? '0 : load_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      wr_ptr      <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      load_done   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      fetch_valid <= fetch_ok;
      load_done   <= 1'b0;
      if (fetch_ok) begin
        fetch_data <= fetch_in_range ? mem[fetch_addr[AW-1:0]] : '0;
      end
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_PTR) begin
            clr_ptr <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        IDLE: begin
          if (load_start) begin
            wr_ptr <= base_ptr;
            state  <= LOAD;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            wr_ptr <= wr_ptr_next;
            if (load_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store with WORD=8, DEPTH=16.
module tb_instruction_store;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       fetch_valid;
  logic       busy;
  logic       load_start;
  logic [7:0] load_base;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt;

  logic [7:0] pat [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'hFF};

  always #5 clk = ~clk;

  instruction_store #(.WORD(8), .DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .busy        (busy),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_done   (load_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
    chk({tag, "_vld"}, {31'd0, fetch_valid}, 32'd1);
    chk(tag, {24'd0, fetch_data}, {24'd0, exp});
  endtask

  task automatic load_word(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Counts edges from reset release until busy drops, bounded at 40.
  task automatic wait_clear(input string tag);
    int n;
    n        = 0;
    done_cnt = 0;
    do begin
      step();
      n++;
      if (load_done) done_cnt++;
    end while (busy && n < 40);
    chk(tag, n, 16);
    chk({tag, "_no_done"}, done_cnt, 0);
  endtask

  initial begin
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_base  = '0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;

    // Reset state and clear sequence
    step();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_fvld", {31'd0, fetch_valid}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_fdata", {24'd0, fetch_data}, 32'd0);
    step();
    rst = 1'b0;
    wait_clear("clear_cycles");

    // Back-to-back fetches of a freshly cleared store
    for (int i = 0; i < 16; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 8'(i);
      step();
      chk($sformatf("clr_vld_%0d", i), {31'd0, fetch_valid}, 32'd1);
      chk($sformatf("clr_dat_%0d", i), {24'd0, fetch_data}, 32'd0);
    end
    fetch_req = 1'b0;
    step();
    chk("clr_idle_vld", {31'd0, fetch_valid}, 32'd0);

    // Load pattern from base 0
    load_start = 1'b1;
    load_base  = 8'h00;
    step();
    load_start = 1'b0;
    chk("pat_busy", {31'd0, busy}, 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      load_word(pat[i], (i == 8));
      if (load_done) done_cnt++;
    end
    chk("pat_done_now", {31'd0, load_done}, 32'd1);
    step();
    if (load_done) done_cnt++;
    chk("pat_done_cnt", done_cnt, 1);
    chk("pat_idle", {31'd0, busy}, 32'd0);
    fetch_chk(8'd9, 8'h00, "pat_a9");
    for (int i = 0; i < 9; i++) begin
      fetch_chk(8'(i), pat[i], $sformatf("pat_a%0d", i));
    end
    step();
    chk("hold_vld", {31'd0, fetch_valid}, 32'd0);
    chk("hold_dat", {24'd0, fetch_data}, 32'hFF);

    // Wrap from base 14, with a fetch accepted alongside load_start
    load_start = 1'b1;
    load_base  = 8'd14;
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    step();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    chk("ls_fetch_vld", {31'd0, fetch_valid}, 32'd1);
    chk("ls_fetch_dat", {24'd0, fetch_data}, 32'h40);
    load_word(8'hA1, 1'b0);
    load_word(8'hA2, 1'b0);
    load_word(8'hA3, 1'b1);
    chk("wrap_done", {31'd0, load_done}, 32'd1);
    step();
    chk("wrap_done_pulse", {31'd0, load_done}, 32'd0);
    fetch_chk(8'd14, 8'hA1, "wrap_a14");
    fetch_chk(8'd15, 8'hA2, "wrap_a15");
    fetch_chk(8'd0, 8'hA3, "wrap_a0");
    fetch_chk(8'd1, 8'h40, "wrap_a1");

    // Stalls, blocked fetches and ignored load_start during LOAD; base 0x13 maps to 3
    load_start = 1'b1;
    load_base  = 8'h13;
    step();
    load_start = 1'b0;
    load_word(8'hC1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      load_data  = 8'hEE;
      load_last  = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = 8'd5;
      load_start = (g == 1);
      load_base  = 8'h0A;
      step();
      chk($sformatf("gap_vld_%0d", g), {31'd0, fetch_valid}, 32'd0);
      chk($sformatf("gap_busy_%0d", g), {31'd0, busy}, 32'd1);
    end
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_last  = 1'b0;
    step();
    chk("gap_blocked_vld", {31'd0, fetch_valid}, 32'd0);
    load_word(8'hC2, 1'b1);
    chk("stall_done", {31'd0, load_done}, 32'd1);
    step();
    fetch_chk(8'd2, 8'h20, "stall_a2");
    fetch_chk(8'd3, 8'hC1, "stall_a3");
    fetch_chk(8'd4, 8'hC2, "stall_a4");
    fetch_chk(8'd5, 8'h04, "stall_a5");
    fetch_chk(8'd10, 8'h00, "stall_a10");

    // Out-of-range fetches must not alias
    fetch_chk(8'h20, 8'h00, "oor_20");
    fetch_chk(8'h10, 8'h00, "oor_10");
    fetch_chk(8'hFF, 8'h00, "oor_ff");

    // load_valid/load_last outside LOAD are ignored
    load_word(8'h99, 1'b1);
    chk("idle_load_done", {31'd0, load_done}, 32'd0);
    chk("idle_load_busy", {31'd0, busy}, 32'd0);
    fetch_chk(8'd5, 8'h04, "idle_load_a5");
    fetch_chk(8'd3, 8'hC1, "pre_rst_a3");

    // Reset in the middle of a load
    load_start = 1'b1;
    load_base  = 8'h00;
    step();
    load_start = 1'b0;
    load_word(8'h55, 1'b0);
    load_word(8'h66, 1'b0);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h77;
    load_last  = 1'b1;
    step();
    rst        = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_fdata", {24'd0, fetch_data}, 32'd0);
    chk("mid_rst_done", {31'd0, load_done}, 32'd0);
    wait_clear("mid_rst_clear");
    for (int i = 0; i < 16; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 8'(i);
      step();
      chk($sformatf("post_rst_vld_%0d", i), {31'd0, fetch_valid}, 32'd1);
      chk($sformatf("post_rst_dat_%0d", i), {24'd0, fetch_data}, 32'd0);
    end
    fetch_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_store.md
INSTRUCTION_STORE -- requirements
Module: instruction_store

Interface
REQ-001 The block SHALL have parameter WORD, default 8: instruction and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256: number of stored words; legal range 2..2**WORD.
REQ-003 The block SHALL have port clk, input, 1: single clock; every register updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port fetch_req, input, 1: read request, sampled on the clock edge.
REQ-006 The block SHALL have port fetch_addr, input, WORD: read address, sampled with fetch_req.
REQ-007 The block SHALL have port fetch_data, output, WORD: registered read data.
REQ-008 The block SHALL have port fetch_valid, output, 1: fetch_data holds the response to an accepted request.
REQ-009 The block SHALL have port busy, output, 1: high during CLEAR or LOAD; fetches are not accepted.
REQ-010 The block SHALL have port load_start, input, 1: single-cycle pulse that opens a load session.
REQ-011 The block SHALL have port load_base, input, WORD: first write address, sampled with load_start.
REQ-012 The block SHALL have port load_valid, input, 1: load_data is to be written this cycle.
REQ-013 The block SHALL have port load_data, input, WORD: word to store.
REQ-014 The block SHALL have port load_last, input, 1: qualified by load_valid; marks the final word of the session.
REQ-015 The block SHALL have port load_done, output, 1: single-cycle pulse one cycle after the last word is written.

Function
REQ-016 The block SHALL implement a state machine with states CLEAR, IDLE and LOAD.
REQ-017 In CLEAR, one location SHALL be zeroed per cycle, from address 0 to DEPTH-1 in order, and the state SHALL go to IDLE after location DEPTH-1 is written (DEPTH cycles).
REQ-018 In IDLE with fetch_req=1, the block SHALL accept the fetch and present the data on the next cycle, with fetch_valid=1 for exactly that one cycle.
REQ-019 Fetch latency SHALL be 1 cycle; back-to-back requests SHALL give back-to-back responses at full throughput.
REQ-020 A fetch with fetch_addr >= DEPTH SHALL return 0 with fetch_valid=1 and SHALL NOT alias to any stored word.
REQ-021 fetch_data SHALL hold its last value while fetch_valid=0.
REQ-022 fetch_req SHALL be ignored while busy=1: no response and no queueing.
REQ-023 In IDLE, load_start=1 SHALL capture load_base modulo DEPTH as the write pointer and move to LOAD on the next cycle; if fetch_req=1 in the same cycle, the fetch SHALL be accepted and answered normally.
REQ-024 load_start SHALL be ignored in CLEAR and in LOAD.
REQ-025 In LOAD, each cycle with load_valid=1 SHALL write load_data at the write pointer and advance the pointer by 1, wrapping from DEPTH-1 to 0.
REQ-026 In LOAD, load_valid=0 SHALL stall with no write and no pointer change; there is no timeout.
REQ-027 load_valid=1 with load_last=1 SHALL write that word, return the state to IDLE on the next edge, and assert load_done for the following single cycle.
REQ-028 load_valid and load_last SHALL be ignored outside LOAD.
REQ-029 A word written in LOAD SHALL be readable by any fetch accepted after the block returns to IDLE.
REQ-030 busy SHALL be a registered output equal to (state != IDLE).

Reset
REQ-031 rst=1 at a clock edge SHALL force state CLEAR and clear pointers to 0, with fetch_valid=0, load_done=0, fetch_data=0 and busy=1 after that edge.
REQ-032 rst SHALL take priority over all other inputs, including mid-LOAD and mid-CLEAR, and SHALL restart the clear sequence from address 0.
REQ-033 After rst deasserts, busy SHALL stay high for exactly DEPTH cycles, and every location SHALL read 0 until it is loaded.

Verification (WORD=8, DEPTH=16)
REQ-034 Reset then count: rst high 2 cycles -> busy=1 for 16 cycles, then busy=0; fetches of addresses 0..15 return 0x00, each with fetch_valid one cycle later.
REQ-035 Load pattern: load_start with base 0, then 9 valid words 80,40,20,10,08,04,02,01,FF (last on FF) -> load_done pulses once; fetches of addresses 0..8 return those words and address 9 returns 00.
REQ-036 Wrap: base 14, then words A1,A2,A3 (last on A3) -> addresses 14, 15 and 0 hold A1, A2, A3 and address 1 is unchanged.
REQ-037 Stall and blocking: a LOAD with load_valid gaps of 3 cycles -> no spurious writes; fetch_req during LOAD -> no fetch_valid; with base 0x13 the first word lands at address 3.
REQ-038 Out-of-range and reset mid-load: a fetch of address 0x20 -> 00 with valid; rst after 2 of 5 load words -> busy for 16 cycles, all locations 00, and no load_done.
